// File: rtl/seq_detect_sched.sv
// -----------------------------------------------------------------------------
// seq_detect_sched
//
// Two bit-stream requesters share one serial consecutive-ones detector.
// A round-robin arbiter grants one requester per frame of FRAME_LEN accepted
// bits. The granted stream is muxed into an overlapping Mealy detector that
// strobes det for every bit that completes a run of RUN_LEN ones. At the end
// of a complete frame the hit total is reported with a one-cycle done pulse.
//
// Ports:
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset
//   req      in   [1:0] frame request per requester (held for the whole frame)
//   bit_in   in   [1:0] serial data bit per requester
//   bit_vld  in   [1:0] bit_in qualifier per requester
//   gnt      out  [1:0] one-hot registered grant
//   busy     out  high while a frame is running or being reported
//   det      out  combinational hit strobe for the currently accepted bit
//   done     out  one-cycle pulse after the last bit of a complete frame
//   done_id  out  requester index of the last completed frame (held)
//   hit_cnt  out  [CNT_W-1:0] hits in the last completed frame (held)
// -----------------------------------------------------------------------------
module seq_detect_sched #(
  parameter int RUN_LEN   = 3,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       bit_in,
  input  logic [1:0]       bit_vld,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             det,
  output logic             done,
  output logic             done_id,
  output logic [CNT_W-1:0] hit_cnt
);

  // The run counter saturates at RUN_LEN-1, so it only needs to hold that.
  localparam int RW = (RUN_LEN > 2) ? $clog2(RUN_LEN) : 1;
  localparam logic [RW-1:0]    RUN_MAX  = RW'(RUN_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             gidx_q, gidx_d;      // index of the granted requester
  logic             ptr_q, ptr_d;        // round-robin priority pointer
  logic [RW-1:0]    run_q, run_d;        // consecutive ones seen so far
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;        // hits in the frame in progress
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;

  // Granted-lane mux; the other lane is never looked at while running.
  logic g_req, g_vld, g_bit, accept, det_w, winner;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      gnt_q     <= 2'b00;
      gidx_q    <= 1'b0;
      ptr_q     <= 1'b0;
      run_q     <= '0;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
      hit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gidx_q    <= gidx_d;
      ptr_q     <= ptr_d;
      run_q     <= run_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  always_comb begin
    g_req  = req[gidx_q];
    g_vld  = bit_vld[gidx_q];
    g_bit  = bit_in[gidx_q];
    // A bit on a cycle where the owner has dropped req belongs to an aborted
    // frame and must not be accepted.
    accept = (state_q == S_RUN) && g_req && g_vld;
    // Overlapping detection: once saturated, every further 1 is another hit.
    det_w  = accept && g_bit && (run_q == RUN_MAX);
    winner = req[ptr_q] ? ptr_q : ~ptr_q;

    state_d   = state_q;
    gnt_d     = gnt_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    run_d     = run_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    hit_cnt_d = hit_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d   = S_RUN;
          gidx_d    = winner;
          gnt_d     = winner ? 2'b10 : 2'b01;
          run_d     = '0;
          bit_cnt_d = '0;
          cnt_d     = '0;
        end
      end

      S_RUN: begin
        if (!g_req) begin
          // Abort: drop the frame silently and give the other side priority.
          state_d = S_IDLE;
          gnt_d   = 2'b00;
          ptr_d   = ~gidx_q;
        end else if (g_vld) begin
          if (g_bit) begin
            run_d = (run_q == RUN_MAX) ? run_q : run_q + RW'(1);
          end else begin
            run_d = '0;
          end
          cnt_d     = cnt_q + CNT_W'(det_w);
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == LAST_BIT) begin
            // The last bit still contributes its own hit to the report.
            state_d   = S_REPORT;
            gnt_d     = 2'b00;
            done_d    = 1'b1;
            done_id_d = gidx_q;
            hit_cnt_d = cnt_q + CNT_W'(det_w);
          end
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
        ptr_d   = ~gidx_q;
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != S_IDLE);
  assign det     = det_w;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
module tb_seq_detect_sched;

  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req;
  logic [1:0]       bit_in;
  logic [1:0]       bit_vld;
  logic [1:0]       gnt;
  logic             busy;
  logic             det;
  logic             done;
  logic             done_id;
  logic [CNT_W-1:0] hit_cnt;

  seq_detect_sched #(.RUN_LEN(3), .FRAME_LEN(16), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .bit_in  (bit_in),
    .bit_vld (bit_vld),
    .gnt     (gnt),
    .busy    (busy),
    .det     (det),
    .done    (done),
    .done_id (done_id),
    .hit_cnt (hit_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scoreboard queues filled by stimulus, drained by the monitor.
  logic       exp_det_q[$];
  logic [1:0] exp_gnt_q[$];
  int         exp_id_q[$];
  int         exp_cnt_q[$];

  // Hand-computed frames: index 0 is the first bit sent.
  localparam logic [15:0] FR_A_BITS = 16'hF1DE; // 0,1,1,1,1,0,1,1,1,0,0,0,1,1,1,1
  localparam logic [15:0] FR_A_DETS = 16'hC118; // hits on bits 4,5,9,15,16
  localparam logic [15:0] FR_B_BITS = 16'h00ED; // 1,0,1,1,0,1,1,1,0,...
  localparam logic [15:0] FR_B_DETS = 16'h0080; // single hit on bit 8
  localparam logic [15:0] ONES_BITS = 16'hFFFF;
  localparam logic [15:0] ONES_DETS = 16'hFFFC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT activity against the scoreboard on the falling edge.
  logic [1:0] prev_gnt = 2'b00;
  always @(negedge clk) begin
    int g;
    g = gnt[1] ? 1 : 0;
    check("gnt_not_two_hot", {31'd0, gnt == 2'b11}, 32'd0);
    if (gnt != 2'b00 && req[g] && bit_vld[g]) begin
      if (exp_det_q.size() == 0) check("det_unexpected_accept", 32'd1, 32'd0);
      else check("det_accepted_bit", {31'd0, det}, {31'd0, exp_det_q.pop_front()});
    end else begin
      check("det_quiet", {31'd0, det}, 32'd0);
    end
    if (gnt != 2'b00 && prev_gnt == 2'b00) begin
      if (exp_gnt_q.size() == 0) check("gnt_unexpected", {30'd0, gnt}, 32'd0);
      else check("gnt_value", {30'd0, gnt}, {30'd0, exp_gnt_q.pop_front()});
    end
    if (done) begin
      if (exp_id_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        check("done_id", {31'd0, done_id}, exp_id_q.pop_front());
        check("hit_cnt", {27'd0, hit_cnt}, exp_cnt_q.pop_front());
        check("gnt_during_done", {30'd0, gnt}, 32'd0);
        check("busy_during_done", {31'd0, busy}, 32'd1);
      end
    end
    prev_gnt = gnt;
  end

  // Wait for gnt[id] with a cycle bound; returns cycles waited, -1 on timeout.
  task automatic wait_gnt(input int id, output int n);
    n = 0;
    while (!gnt[id] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!gnt[id]) begin
      check("gnt_timeout", {30'd0, gnt}, 32'd1 << id);
      n = -1;
    end
  endtask

  // One full frame on lane id. The other lane carries inverted data with
  // bit_vld high so that listening to the wrong lane changes the outcome.
  task automatic run_frame(input int id, input logic [15:0] bits, input logic [15:0] dets,
                           input int cnt, input int stall_at, input bit chk_lat);
    int n;
    exp_gnt_q.push_back(2'b01 << id);
    exp_id_q.push_back(id);
    exp_cnt_q.push_back(cnt);
    wait_gnt(id, n);
    if (n < 0) return;
    if (chk_lat) check("gnt_latency", n, 32'd1);
    for (int i = 0; i < 16; i++) begin
      if (i == stall_at) begin
        for (int s = 0; s < 3; s++) begin
          bit_vld[id] = 1'b0; bit_in[id] = 1'b0;
          bit_vld[1-id] = 1'b1; bit_in[1-id] = 1'b1;
          @(posedge clk); #1;
        end
      end
      bit_vld[id] = 1'b1; bit_in[id] = bits[i];
      bit_vld[1-id] = 1'b1; bit_in[1-id] = ~bits[i];
      exp_det_q.push_back(dets[i]);
      @(posedge clk); #1;
    end
    bit_vld = 2'b00; bit_in = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; req = 2'b00; bit_in = 2'b00; bit_vld = 2'b00;
    @(posedge clk); #1;
    check("reset_gnt", {30'd0, gnt}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_done_id", {31'd0, done_id}, 32'd0);
    check("reset_hit_cnt", {27'd0, hit_cnt}, 32'd0);
    check("reset_det", {31'd0, det}, 32'd0);
    reset = 1'b0;

    // Basic frame, stalled frame, then a frame proving the run is cleared.
    req = 2'b01;
    run_frame(0, FR_A_BITS, FR_A_DETS, 5, -1, 1'b1);
    run_frame(0, FR_A_BITS, FR_A_DETS, 5, 3, 1'b0);
    run_frame(0, FR_B_BITS, FR_B_DETS, 1, -1, 1'b0);
    req = 2'b00;
    repeat (3) @(posedge clk);
    #1;

    // Fairness from reset with both requesting continuously.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; req = 2'b11;
    run_frame(0, ONES_BITS, ONES_DETS, 14, -1, 1'b1);
    run_frame(1, ONES_BITS, ONES_DETS, 14, -1, 1'b0);
    run_frame(0, ONES_BITS, ONES_DETS, 14, -1, 1'b0);
    run_frame(1, ONES_BITS, ONES_DETS, 14, -1, 1'b0);

    // Abort of requester 0 after 7 accepted bits.
    exp_gnt_q.push_back(2'b01);
    wait_gnt(0, n);
    for (int i = 0; i < 7; i++) begin
      bit_vld[0] = 1'b1; bit_in[0] = 1'b1;
      exp_det_q.push_back(i >= 2);
      @(posedge clk); #1;
    end
    req = 2'b10;
    @(posedge clk); #1;
    check("abort_gnt", {30'd0, gnt}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_done", {31'd0, done}, 32'd0);
    check("abort_hit_cnt_held", {27'd0, hit_cnt}, 32'd14);
    check("abort_done_id_held", {31'd0, done_id}, 32'd1);
    bit_vld = 2'b00; bit_in = 2'b00; req = 2'b11;
    run_frame(1, FR_A_BITS, FR_A_DETS, 5, -1, 1'b1);

    // Reset in the middle of a frame.
    exp_gnt_q.push_back(2'b01);
    wait_gnt(0, n);
    for (int i = 0; i < 10; i++) begin
      bit_vld[0] = 1'b1; bit_in[0] = 1'b1;
      exp_det_q.push_back(i >= 2);
      @(posedge clk); #1;
    end
    bit_vld = 2'b00; bit_in = 2'b00; reset = 1'b1;
    @(posedge clk); #1;
    check("midreset_gnt", {30'd0, gnt}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_done_id", {31'd0, done_id}, 32'd0);
    check("midreset_hit_cnt", {27'd0, hit_cnt}, 32'd0);
    reset = 1'b0;
    run_frame(0, ONES_BITS, ONES_DETS, 14, -1, 1'b1);
    req = 2'b00;
    repeat (4) @(posedge clk);
    #1;

    check("det_queue_drained", exp_det_q.size(), 32'd0);
    check("gnt_queue_drained", exp_gnt_q.size(), 32'd0);
    check("done_queue_drained", exp_id_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Round-robin scheduler sharing one serial consecutive-ones detector (overlapping Mealy) between two bit-stream requesters.
- Grants one requester per frame of FRAME_LEN bits and muxes its bit stream into the detector.
- Counts overlapping runs of RUN_LEN consecutive 1s and reports the per-frame hit count with a done pulse.
- Sits between the serial input front-ends and the status/interrupt logic.

Parameters:
- RUN_LEN, 3, consecutive 1s needed for a hit; must be >= 2.
- FRAME_LEN, 16, accepted bits per granted frame; must be >= RUN_LEN.
- CNT_W, 5, width of hit_cnt and the bit counter; must satisfy 2^CNT_W > FRAME_LEN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  2  req[i] high: requester i wants a frame; must stay high for the whole frame.
- bit_in  input  2  bit_in[i]: serial data bit from requester i.
- bit_vld  input  2  bit_vld[i]: bit_in[i] is valid this cycle.
- gnt  output  2  one-hot, registered; requester i owns the detector.
- busy  output  1  high in RUN and REPORT.
- det  output  1  Mealy hit strobe; combinational from the current accepted bit.
- done  output  1  one-cycle pulse at the end of a complete frame.
- done_id  output  1  requester index of the completed frame; valid with done and held until the next done.
- hit_cnt  output  CNT_W  hits in the last completed frame; held until the next done.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, gnt=0, busy=0, done=0, done_id=0, hit_cnt=0, run/bit/internal counters=0, RR pointer=0 (requester 0 wins first). Reset is honoured in any state; a frame in progress is discarded with no done.
- State IDLE:
  - If any req is high, pick the winner: the pointer requester if it requests, else the other.
  - Next cycle: gnt[winner]=1, state=RUN. Latency from req to gnt is 1 cycle.
  - Run counter and bit counter cleared on entry to RUN; no run carries across frames.
- State RUN:
  - A bit is accepted only in a cycle where bit_vld[g] is high (g = granted index). bit_vld low cycles are stalls and do not break a run.
  - Accepted 1: run_cnt = min(run_cnt+1, RUN_LEN-1).
  - Accepted 0: run_cnt = 0.
  - det = accepted && bit==1 && run_cnt==RUN_LEN-1. This is overlapping detection: e.g. five 1s with RUN_LEN=3 give 3 hits.
  - Internal count increments on each det. Width is CNT_W; overflow is impossible by the parameter rule.
  - On acceptance of the FRAME_LEN-th bit (that bit still counted and checked for det): next state REPORT, gnt=0.
  - Abort: if req[g] is low in any RUN cycle, next state IDLE, gnt=0, no done, hit_cnt/done_id unchanged, pointer advances. Any bit on that cycle is ignored.
  - The non-granted requester's bit_vld and bit_in are ignored.
- State REPORT (exactly 1 cycle):
  - done=1, done_id=g, hit_cnt=internal count (registered outputs visible this cycle).
  - Pointer moves to the other requester.
  - Next state IDLE; a new grant can be issued at the earliest the following cycle.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1…
- det is 0 outside RUN. gnt is never two-hot.

Test Plan:
- Reset, req=01, requester 0 sends (first to last) 0,1,1,1,1,0,1,1,1,0,0,0,1,1,1,1 with bit_vld=1 -> gnt=01 one cycle after req; det on bits 4,5,9,15,16; done=1 with done_id=0, hit_cnt=5 one cycle after the last bit; gnt=00 during done.
- Same frame with bit_vld low for 3 cycles between bits 3 and 4, and bit_in=0 while invalid -> still hit_cnt=5; det never high on stall cycles.
- req=11 held from reset across 4 frames of all-ones -> gnt sequence 01,10,01,10; each done has hit_cnt=14; done_id=0,1,0,1.
- Requester 0 frame ends 0,…,1,1, next frame from requester 0 starts 1,0,… -> no det on the first bit of the new frame (run cleared at frame start).
- req[0] dropped after 7 accepted bits -> gnt=00 next cycle, no done, hit_cnt keeps its previous value; with req=11 the next grant goes to requester 1.
- reset asserted mid-RUN after 10 bits -> next cycle all outputs 0, state IDLE, pointer=0; with req=11 the first grant is 01.
